// File: rtl/hash_pkg.sv
// Shared types for the multi-lane leading-zero digest selector.
package hash_pkg;

    localparam int DIGEST_BITS = 128;
    localparam int NONCE_BITS  = 32;

    typedef logic [DIGEST_BITS-1:0] digest_t;
    typedef logic [NONCE_BITS-1:0]  nonce_t;

    typedef enum logic [1:0] {
        SEARCH,
        DRAIN,
        DONE
    } state_t;

    // Mask with the top 4*n bits set; a digest meets threshold n when (digest & mask) == 0.
    function automatic digest_t zero_mask(input int unsigned n);
        zero_mask = ~(digest_t'('1) >> (4 * n));
    endfunction

endpackage

// File: rtl/lane_min_select.sv
// Combinational binary compare tree: finds the hit lane with the smallest nonce,
// breaking ties towards the lowest lane index.
module lane_min_select #(
    parameter int NUM_LANES   = 4,
    parameter int NONCE_WIDTH = 32,
    parameter int IDX_WIDTH   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0]             hit,
    input  logic [NUM_LANES*NONCE_WIDTH-1:0] nonce,
    output logic                             valid,
    output logic [NONCE_WIDTH-1:0]           min_nonce,
    output logic [IDX_WIDTH-1:0]             index
);

    localparam int PAD   = 1 << $clog2(NUM_LANES);
    localparam int NODES = 2 * PAD - 1;

    logic                   node_valid [NODES];
    logic [NONCE_WIDTH-1:0] node_nonce [NODES];
    logic [IDX_WIDTH-1:0]   node_idx   [NODES];

    // Heap layout: leaves PAD-1.. hold lanes in ascending order, so a left child always
    // carries the lower lane index and wins a tie.
    always_comb begin
        for (int k = 0; k < NODES; k++) begin
            node_valid[k] = 1'b0;
            node_nonce[k] = '0;
            node_idx[k]   = '0;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            node_valid[PAD-1+i] = hit[i];
            node_nonce[PAD-1+i] = nonce[i*NONCE_WIDTH +: NONCE_WIDTH];
            node_idx[PAD-1+i]   = IDX_WIDTH'(i);
        end
        for (int k = PAD - 2; k >= 0; k--) begin
            if (node_valid[2*k+2] &&
                (!node_valid[2*k+1] || (node_nonce[2*k+2] < node_nonce[2*k+1]))) begin
                node_valid[k] = 1'b1;
                node_nonce[k] = node_nonce[2*k+2];
                node_idx[k]   = node_idx[2*k+2];
            end else begin
                node_valid[k] = node_valid[2*k+1];
                node_nonce[k] = node_nonce[2*k+1];
                node_idx[k]   = node_idx[2*k+1];
            end
        end
    end

    assign valid     = node_valid[0];
    assign min_nonce = node_nonce[0];
    assign index     = node_idx[0];

endmodule

// File: rtl/hash_match_selector.sv
// Multi-lane leading-zero digest filter: keeps the lowest matching nonce, stops the
// cores on the first match and keeps collecting for a drain window before finalising.
module hash_match_selector
    import hash_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int DIGEST_WIDTH = 128,
    parameter int NONCE_WIDTH  = 32,
    parameter int MAX_NIBBLES  = 8,
    parameter int DRAIN_CYCLES = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(MAX_NIBBLES+1)-1:0]  leading_zeroes,
    input  logic [NUM_LANES-1:0]              digest_valid,
    input  logic [NUM_LANES*DIGEST_WIDTH-1:0] digest_data,
    input  logic [NUM_LANES*NONCE_WIDTH-1:0]  digest_nonce,
    output logic                              search_stop,
    output logic                              match_valid,
    output logic [NONCE_WIDTH-1:0]            match_nonce,
    output logic [DIGEST_WIDTH-1:0]           match_data,
    output logic [COUNT_WIDTH-1:0]            match_count
);

    localparam int LZ_W       = $clog2(MAX_NIBBLES + 1);
    localparam int IDX_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int POP_W      = $clog2(NUM_LANES + 1);
    localparam int DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    logic [LZ_W-1:0]                   thr;
    logic [DIGEST_WIDTH-1:0]           mask;
    logic [NUM_LANES-1:0]              lane_hit;

    logic [NUM_LANES-1:0]              s1_hit;
    logic [NUM_LANES*NONCE_WIDTH-1:0]  s1_nonce;
    logic [NUM_LANES*DIGEST_WIDTH-1:0] s1_data;

    logic                              sel_valid;
    logic [NONCE_WIDTH-1:0]            sel_nonce;
    logic [IDX_W-1:0]                  sel_index;
    logic [POP_W-1:0]                  s1_pop;

    logic                              s2_valid;
    logic [NONCE_WIDTH-1:0]            s2_nonce;
    logic [DIGEST_WIDTH-1:0]           s2_data;
    logic [POP_W-1:0]                  s2_pop;

    logic                              best_valid;
    logic [NONCE_WIDTH-1:0]            best_nonce;
    logic [DIGEST_WIDTH-1:0]           best_data;
    logic [COUNT_WIDTH:0]              count_sum;

    state_t                            state;
    state_t                            next_state;
    logic [DRAIN_W-1:0]                drain_cnt;
    logic [DRAIN_W-1:0]                drain_next;
    logic                              collecting;

    // Thresholds above MAX_NIBBLES are clipped silently.
    assign thr  = (leading_zeroes > LZ_W'(MAX_NIBBLES)) ? LZ_W'(MAX_NIBBLES) : leading_zeroes;
    assign mask = ~({DIGEST_WIDTH{1'b1}} >> (4 * thr));

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_hit[i] = digest_valid[i] &&
                          ((digest_data[i*DIGEST_WIDTH +: DIGEST_WIDTH] & mask) == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit   <= '0;
            s1_nonce <= '0;
            s1_data  <= '0;
        end else begin
            s1_hit   <= lane_hit;
            s1_nonce <= digest_nonce;
            s1_data  <= digest_data;
        end
    end

    lane_min_select #(
        .NUM_LANES  (NUM_LANES),
        .NONCE_WIDTH(NONCE_WIDTH),
        .IDX_WIDTH  (IDX_W)
    ) u_min_select (
        .hit      (s1_hit),
        .nonce    (s1_nonce),
        .valid    (sel_valid),
        .min_nonce(sel_nonce),
        .index    (sel_index)
    );

    assign s1_pop = POP_W'($countones(s1_hit));

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_nonce <= '0;
            s2_data  <= '0;
            s2_pop   <= '0;
        end else begin
            s2_valid <= sel_valid;
            s2_nonce <= sel_nonce;
            s2_data  <= s1_data[sel_index*DIGEST_WIDTH +: DIGEST_WIDTH];
            s2_pop   <= s1_pop;
        end
    end

    assign collecting = (state != DONE);

    always_comb begin
        next_state = state;
        drain_next = drain_cnt;
        case (state)
            SEARCH: begin
                if (s2_valid) begin
                    if (DRAIN_CYCLES == 0) begin
                        next_state = DONE;
                    end else begin
                        next_state = DRAIN;
                        drain_next = DRAIN_W'(DRAIN_LOAD);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = DONE;
                end else begin
                    drain_next = drain_cnt - 1'b1;
                end
            end
            DONE:    next_state = DONE;
            default: next_state = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            drain_cnt   <= '0;
            search_stop <= 1'b0;
            match_valid <= 1'b0;
        end else begin
            state       <= next_state;
            drain_cnt   <= drain_next;
            search_stop <= (next_state != SEARCH);
            match_valid <= (next_state == DONE);
        end
    end

    // An equal nonce keeps the incumbent, so the earlier arrival wins ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_valid <= 1'b0;
            best_nonce <= '0;
            best_data  <= '0;
        end else if (collecting && s2_valid && (!best_valid || (s2_nonce < best_nonce))) begin
            best_valid <= 1'b1;
            best_nonce <= s2_nonce;
            best_data  <= s2_data;
        end
    end

    assign count_sum = {1'b0, match_count} + (COUNT_WIDTH+1)'(s2_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (collecting) begin
            match_count <= count_sum[COUNT_WIDTH] ? '1 : count_sum[COUNT_WIDTH-1:0];
        end
    end

    assign match_nonce = best_nonce;
    assign match_data  = best_data;

endmodule

// File: tb/tb_hash_match_selector.sv
// Bench for hash_match_selector: a window-based reference model checked every cycle
// against a 16-cycle-drain build and a zero-drain build sharing the same stimulus.
module tb_hash_match_selector;

    localparam int NL = 4;
    localparam int DW = 128;
    localparam int NW = 32;

    typedef struct {
        int          cyc;
        int          lane;
        logic [31:0] nonce;
        logic [127:0] data;
    } hit_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      leading_zeroes;
    logic [NL-1:0]   digest_valid;
    logic [NL*DW-1:0] digest_data;
    logic [NL*NW-1:0] digest_nonce;

    logic            stop16, valid16, stop0, valid0;
    logic [NW-1:0]   nonce16, nonce0;
    logic [DW-1:0]   data16, data0;
    logic [15:0]     count16, count0;

    int              n_checks = 0;
    int              n_fail = 0;
    bit              cmp_en = 1'b0;

    hit_t            hits[$];
    int              cyc_cnt = 0;

    logic [NL-1:0]   sv;
    logic [DW-1:0]   sd [NL];
    logic [NW-1:0]   sn [NL];

    hash_match_selector #(
        .NUM_LANES(NL), .DIGEST_WIDTH(DW), .NONCE_WIDTH(NW),
        .MAX_NIBBLES(8), .DRAIN_CYCLES(16), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .leading_zeroes(leading_zeroes),
        .digest_valid(digest_valid), .digest_data(digest_data), .digest_nonce(digest_nonce),
        .search_stop(stop16), .match_valid(valid16), .match_nonce(nonce16),
        .match_data(data16), .match_count(count16)
    );

    hash_match_selector #(
        .NUM_LANES(NL), .DIGEST_WIDTH(DW), .NONCE_WIDTH(NW),
        .MAX_NIBBLES(8), .DRAIN_CYCLES(0), .COUNT_WIDTH(16)
    ) dut0 (
        .clk(clk), .reset(reset), .leading_zeroes(leading_zeroes),
        .digest_valid(digest_valid), .digest_data(digest_data), .digest_nonce(digest_nonce),
        .search_stop(stop0), .match_valid(valid0), .match_nonce(nonce0),
        .match_data(data0), .match_count(count0)
    );

    always #5 clk = ~clk;

    function automatic bit model_hit(input logic [127:0] d, input int lz);
        int n;
        n = (lz > 8) ? 8 : lz;
        for (int j = 0; j < n; j++) begin
            if (d[127-4*j -: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Outputs after the latest edge reflect hits sampled up to two edges earlier, limited
    // to the window [first hit, first hit + drain].
    function automatic void model(input int d, output logic stop, output logic mv,
                                  output logic [31:0] n, output logic [127:0] dat,
                                  output int cnt);
        int  k0;
        int  last;
        bit  found;
        stop = 1'b0; mv = 1'b0; n = '0; dat = '0; cnt = 0; found = 1'b0;
        if (hits.size() == 0) return;
        k0 = hits[0].cyc;
        if (k0 > cyc_cnt - 3) return;
        stop = 1'b1;
        mv   = (k0 + d <= cyc_cnt - 3);
        last = (cyc_cnt - 3 < k0 + d) ? cyc_cnt - 3 : k0 + d;
        foreach (hits[j]) begin
            if (hits[j].cyc <= last) begin
                cnt++;
                if (!found || hits[j].nonce < n) begin
                    n     = hits[j].nonce;
                    dat   = hits[j].data;
                    found = 1'b1;
                end
            end
        end
        if (cnt > 65535) cnt = 65535;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            hits.delete();
            cyc_cnt = 0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (digest_valid[i] && model_hit(digest_data[i*DW +: DW], int'(leading_zeroes))) begin
                    hits.push_back('{cyc_cnt, i, digest_nonce[i*NW +: NW], digest_data[i*DW +: DW]});
                end
            end
            cyc_cnt++;
        end
    end

    always @(negedge clk) begin
        logic         e_stop, e_mv;
        logic [31:0]  e_n;
        logic [127:0] e_d;
        int           e_c;
        if (cmp_en) begin
            model(16, e_stop, e_mv, e_n, e_d, e_c);
            checkOutput("stop16", 128'(stop16), 128'(e_stop));
            checkOutput("valid16", 128'(valid16), 128'(e_mv));
            checkOutput("nonce16", 128'(nonce16), 128'(e_n));
            checkOutput("data16", data16, e_d);
            checkOutput("count16", 128'(count16), 128'(e_c));
            model(0, e_stop, e_mv, e_n, e_d, e_c);
            checkOutput("stop0", 128'(stop0), 128'(e_stop));
            checkOutput("valid0", 128'(valid0), 128'(e_mv));
            checkOutput("nonce0", 128'(nonce0), 128'(e_n));
            checkOutput("data0", data0, e_d);
            checkOutput("count0", 128'(count0), 128'(e_c));
        end
    end

    task automatic applyStimulus();
        for (int i = 0; i < NL; i++) begin
            digest_data[i*DW +: DW]  = sd[i];
            digest_nonce[i*NW +: NW] = sn[i];
        end
        digest_valid = sv;
        @(negedge clk);
        digest_valid = '0;
        sv = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        digest_valid = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clearLanes();
        sv = '0;
        for (int i = 0; i < NL; i++) begin
            sd[i] = '1;
            sn[i] = '0;
        end
    endtask

    initial begin
        reset = 1'b1;
        leading_zeroes = 4'd5;
        digest_valid = '0;
        digest_data = '0;
        digest_nonce = '0;
        clearLanes();
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_stop", 128'(stop16), 128'(0));
        checkOutput("reset_count", 128'(count16), 128'(0));
        reset = 1'b0;
        idle(2);

        // Single hit on lane 2: stop three edges after sampling, final 16 edges later.
        $display("[TB] single hit latency");
        clearLanes();
        sv[2] = 1'b1; sd[2] = {24'h00000F, 104'h1234}; sn[2] = 32'd100;
        applyStimulus();
        idle(1);
        checkOutput("t1_stop_early", 128'(stop16), 128'(0));
        checkOutput("t1_d0_early", 128'({stop0, valid0}), 128'(2'b00));
        idle(1);
        checkOutput("t1_stop", 128'(stop16), 128'(1));
        checkOutput("t1_d0_both", 128'({stop0, valid0}), 128'(2'b11));
        idle(15);
        checkOutput("t1_valid_early", 128'(valid16), 128'(0));
        idle(1);
        checkOutput("t1_valid", 128'(valid16), 128'(1));
        checkOutput("t1_nonce", 128'(nonce16), 128'(100));
        checkOutput("t1_count", 128'(count16), 128'(1));

        // Same-cycle hits with a nonce tie: lowest lane wins.
        $display("[TB] same-cycle tie");
        doReset();
        clearLanes();
        sv = 4'b1011;
        for (int i = 0; i < NL; i++) sd[i] = {24'h00000F, 72'h0, 32'(i + 1)};
        sn[0] = 32'd50; sn[1] = 32'd20; sn[3] = 32'd20;
        applyStimulus();
        idle(20);
        checkOutput("t2_nonce", 128'(nonce16), 128'(20));
        checkOutput("t2_data", data16, {24'h00000F, 72'h0, 32'h2});
        checkOutput("t2_count", 128'(count16), 128'(3));

        // Later but lower nonce inside the drain window, then a post-DONE hit ignored.
        $display("[TB] drain window");
        doReset();
        clearLanes();
        sv[3] = 1'b1; sd[3] = {24'h000000, 104'h9}; sn[3] = 32'd900;
        applyStimulus();
        idle(4);
        sv[0] = 1'b1; sd[0] = {24'h000003, 104'h4}; sn[0] = 32'd400;
        applyStimulus();
        idle(20);
        checkOutput("t3_nonce", 128'(nonce16), 128'(400));
        checkOutput("t3_d0_nonce", 128'(nonce0), 128'(900));
        sv[2] = 1'b1; sd[2] = '0; sn[2] = 32'd10;
        applyStimulus();
        idle(5);
        checkOutput("t3_after_done", 128'(nonce16), 128'(400));
        checkOutput("t3_count", 128'(count16), 128'(2));

        // Zero threshold: every valid digest hits.
        $display("[TB] thresholds");
        doReset();
        leading_zeroes = 4'd0;
        sv = 4'hF;
        for (int i = 0; i < NL; i++) begin
            sd[i] = {$urandom, $urandom, $urandom, $urandom} | {4'hF, 124'h0};
            sn[i] = 32'(33 + i);
        end
        applyStimulus();
        idle(20);
        checkOutput("t4_n0_nonce", 128'(nonce16), 128'(33));
        checkOutput("t4_n0_count", 128'(count16), 128'(4));

        doReset();
        leading_zeroes = 4'd6;
        clearLanes();
        sv[0] = 1'b1; sd[0] = {24'h000001, 104'h0}; sn[0] = 32'd5;
        applyStimulus();
        idle(6);
        checkOutput("t4_n6_miss", 128'(stop16), 128'(0));
        sv[1] = 1'b1; sd[1] = {28'h000000F, 100'h0}; sn[1] = 32'd77;
        applyStimulus();
        idle(20);
        checkOutput("t4_n6_hit", 128'(nonce16), 128'(77));

        // Threshold above the maximum clips to eight nibbles.
        doReset();
        leading_zeroes = 4'd15;
        clearLanes();
        sv[3] = 1'b1; sd[3] = {36'h00000000F, 92'h0}; sn[3] = 32'd61;
        applyStimulus();
        idle(20);
        checkOutput("t4_clip", 128'(nonce16), 128'(61));

        // Reset in the middle of the drain window, then a fresh search.
        $display("[TB] mid-drain reset");
        doReset();
        leading_zeroes = 4'd5;
        clearLanes();
        sv[1] = 1'b1; sd[1] = '0; sn[1] = 32'd55;
        applyStimulus();
        idle(8);
        doReset();
        checkOutput("t6_stop", 128'(stop16), 128'(0));
        checkOutput("t6_nonce", 128'(nonce16), 128'(0));
        checkOutput("t6_count", 128'(count16), 128'(0));
        sv[2] = 1'b1; sd[2] = '0; sn[2] = 32'd7;
        applyStimulus();
        idle(20);
        checkOutput("t6_new_nonce", 128'(nonce16), 128'(7));
        checkOutput("t6_new_valid", 128'(valid16), 128'(1));

        // Randomised rounds with small nonces to exercise ties and the drain cut-off.
        $display("[TB] random rounds");
        for (int r = 0; r < 20; r++) begin
            doReset();
            leading_zeroes = 4'($urandom_range(0, 12));
            for (int c = 0; c < 30; c++) begin
                for (int i = 0; i < NL; i++) begin
                    sv[i] = ($urandom_range(0, 5) == 0);
                    sd[i] = {$urandom, $urandom, $urandom, $urandom} >> (4 * $urandom_range(0, 10));
                    sn[i] = 32'($urandom_range(0, 63));
                end
                applyStimulus();
            end
        end

        idle(2);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
